// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: operation codes and FSM state encoding.
// Used by multicycle_alu and md_unit via import alu_pkg::*.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/md_unit.sv
// Iterative unsigned multiply / restoring divide datapath, one step per clock.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   load           latch a/b/is_div and start a WIDTH-step operation
//   is_div         1 = divide (lo=quotient, hi=remainder), 0 = multiply
//   a, b           operands (multiplier/dividend, multiplicand/divisor)
//   lo, hi         value of the working registers after this cycle's step
//   done           high during the cycle in which the final (WIDTH-th) step happens
module md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             run_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] lo_q, hi_q, b_q;
    logic [WIDTH-1:0] lo_n, hi_n;
    logic [WIDTH:0]   sum, shifted, diff;

    // lo/hi are exposed post-step so the caller can register the final
    // value on the same edge that performs the last step.
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, b_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        lo_n    = lo_q;
        hi_n    = hi_q;
        if (div_q) begin
            // Restoring step; b=0 always "fits", giving all-ones quotient and rem=a.
            if (shifted >= {1'b0, b_q}) begin
                hi_n = diff[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add: carry of the partial sum shifts into the high word.
            if (lo_q[0]) begin
                {hi_n, lo_n} = {sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_n, lo_n} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    assign done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign lo   = lo_n;
    assign hi   = hi_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            b_q   <= '0;
        end else if (load) begin
            run_q <= 1'b1;
            div_q <= is_div;
            cnt_q <= '0;
            lo_q  <= a;
            hi_q  <= '0;
            b_q   <= b;
        end else if (run_q) begin
            lo_q  <= lo_n;
            hi_q  <= hi_n;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU with start/ready/valid handshake.
// Single-cycle ops complete in 1 cycle; mulu/divu take WIDTH+1 cycles via md_unit.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start, operation     request and 4-bit op code, sampled when ready=1
//   a, b                 operands, sampled at acceptance
//   ready                request can be accepted this cycle
//   valid_out            one-cycle pulse when result/result_hi/zero update
//   result, result_hi    low word / quotient, high word / remainder (0 for 1-cycle ops)
//   zero                 registered (result == 0)
//   overflow             signed add/sub overflow, present only with ALU_OVERFLOW_EN defined
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    state_t           state_q, state_d;
    logic             accept, is_md;
    logic             valid_d, md_load, md_done;
    logic [WIDTH-1:0] alu_res, res_d, hi_d, md_lo, md_hi;

    assign ready  = (state_q != BUSY);
    assign accept = start && ready;
    assign is_md  = (operation == OP_MULU) || (operation == OP_DIVU);

    always_comb begin
        alu_res = '0;
        case (operation)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        md_load = 1'b0;
        res_d   = md_lo;
        hi_d    = md_hi;
        case (state_q)
            BUSY: begin
                if (md_done) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end
            // DONE behaves like IDLE so back-to-back requests lose no cycle.
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (is_md) begin
                        md_load = 1'b1;
                        state_d = BUSY;
                    end else begin
                        valid_d = 1'b1;
                        res_d   = alu_res;
                        hi_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    md_unit #(
        .WIDTH(WIDTH)
    ) u_md_unit (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .is_div (operation == OP_DIVU),
        .a      (a),
        .b      (b),
        .lo     (md_lo),
        .hi     (md_hi),
        .done   (md_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_out <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
        end else begin
            state_q   <= state_d;
            valid_out <= valid_d;
            if (valid_d) begin
                result    <= res_d;
                result_hi <= hi_d;
                zero      <= (res_d == '0);
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        if (operation == OP_ADD) begin
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
        end else if (operation == OP_SUB) begin
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
        end
    end

    // Only 1-cycle results can overflow; mul/div completions clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (valid_d) begin
            overflow <= (state_q != BUSY) && alu_ovf;
        end
    end
`endif

endmodule
